wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 27 ++
 rtl/wb_arbiter.sv | 100 ++++++++++
 tb/tb_wb_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three writeback request sources, the register file
// write port, the issue-side scoreboard inputs and the pending-write mask.
interface wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*AW-1:0] req_waddr;
  logic [3*DW-1:0] req_wdata;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [31:0]     pend_mask;

  modport master (
    output req_valid, req_waddr, req_wdata, iss_valid, iss_rd,
    input  req_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );

  modport slave (
    input  req_valid, req_waddr, req_wdata, iss_valid, iss_rd,
    output req_ready, rf_we, rf_waddr, rf_wdata, pend_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of ALU/MEM/MULDIV per cycle into a registered
// register-file write port and tracks pending writes. WB_ARB_RR_EN selects round-robin.
module wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic        clk,
  input  logic        rstn,
  wb_arbiter_if.slave bus
);

  logic [2:0]    grant;
  logic [AW-1:0] sel_waddr;
  logic [DW-1:0] sel_wdata;
  logic [31:0]   clr;
  logic [31:0]   set;

`ifdef WB_ARB_RR_EN
  typedef enum logic [1:0] {
    PRI_ALU    = 2'd0,
    PRI_MEM    = 2'd1,
    PRI_MULDIV = 2'd2
  } pri_e;

  pri_e       ptr;
  pri_e       ptr_next;
  logic [2:0] rot;
  logic [2:0] rot_grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= PRI_ALU;
    else       ptr <= ptr_next;
  end

  // Rotate so the pointed-to source sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot       = bus.req_valid;
    grant     = '0;
    ptr_next  = ptr;
    case (ptr)
      PRI_MEM:    rot = {bus.req_valid[0], bus.req_valid[2], bus.req_valid[1]};
      PRI_MULDIV: rot = {bus.req_valid[1], bus.req_valid[0], bus.req_valid[2]};
      default:    rot = bus.req_valid;
    endcase
    rot_grant = rot & (~rot + 3'd1);
    case (ptr)
      PRI_MEM:    grant = {rot_grant[1], rot_grant[0], rot_grant[2]};
      PRI_MULDIV: grant = {rot_grant[0], rot_grant[2], rot_grant[1]};
      default:    grant = rot_grant;
    endcase
    if (!rstn) grant = '0;
    if (grant[0])      ptr_next = PRI_MEM;
    else if (grant[1]) ptr_next = PRI_MULDIV;
    else if (grant[2]) ptr_next = PRI_ALU;
  end
`else
  always_comb begin
    grant = bus.req_valid & (~bus.req_valid + 3'd1);
    if (!rstn) grant = '0;
  end
`endif

  assign bus.req_ready = grant;

  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        sel_waddr = bus.req_waddr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= (|grant) && (sel_waddr != '0);
      if (|grant) begin
        bus.rf_waddr <= sel_waddr;
        bus.rf_wdata <= sel_wdata;
      end
    end
  end

  assign clr = bus.rf_we ? (32'd1 << bus.rf_waddr) : 32'd0;
  assign set = (bus.iss_valid && (bus.iss_rd != '0)) ? (32'd1 << bus.iss_rd) : 32'd0;

  // Set is OR-ed in after the clear so a same-edge issue keeps its bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.pend_mask <= '0;
    else       bus.pend_mask <= ((bus.pend_mask & ~clr) | set) & ~32'd1;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random traffic, checked
// against a rule-level reference model (honours WB_ARB_RR_EN like the design).
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int            rrPtr;
  bit            modelWe;
  logic [AW-1:0] modelWaddr;
  logic [DW-1:0] modelWdata;
  bit            pendModel[32];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    rrPtr      = 0;
    modelWe    = 1'b0;
    modelWaddr = '0;
    modelWdata = '0;
    for (int r = 0; r < 32; r++) pendModel[r] = 1'b0;
  endfunction

  // Search order starts at the priority pointer (always 0 for fixed priority).
  function automatic int modelPick(input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      if (v[(rrPtr + k) % 3]) return (rrPtr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pendVector();
    logic [31:0] m;
    for (int r = 0; r < 32; r++) m[r] = pendModel[r];
    return m;
  endfunction

  function automatic void modelEdge(input int pick, input logic [3*AW-1:0] a, input logic [3*DW-1:0] d,
                                    input bit iv, input logic [AW-1:0] rd);
    if (modelWe) pendModel[modelWaddr] = 1'b0;
    if (iv && rd != 0) pendModel[rd] = 1'b1;
    if (pick >= 0) begin
      modelWaddr = a[pick*AW +: AW];
      modelWdata = d[pick*DW +: DW];
      modelWe    = (modelWaddr != 0);
`ifdef WB_ARB_RR_EN
      rrPtr = (pick + 1) % 3;
`endif
    end else begin
      modelWe = 1'b0;
    end
  endfunction

  // Called at a falling edge: drive, check grant, take the rising edge, check registers.
  task automatic applyStimulus(input logic [2:0] v, input logic [3*AW-1:0] a, input logic [3*DW-1:0] d,
                               input bit iv, input logic [AW-1:0] rd);
    int pick;
    bus.req_valid = v;
    bus.req_waddr = a;
    bus.req_wdata = d;
    bus.iss_valid = iv;
    bus.iss_rd    = rd;
    #1;
    pick = modelPick(v);
    checkOutput("req_ready", {29'd0, bus.req_ready}, (pick < 0) ? 32'd0 : (32'd1 << pick));
    @(posedge clk);
    #1;
    modelEdge(pick, a, d, iv, rd);
    checkOutput("rf_we", {31'd0, bus.rf_we}, {31'd0, modelWe});
    checkOutput("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, modelWaddr});
    checkOutput("rf_wdata", bus.rf_wdata, modelWdata);
    checkOutput("pend_mask", bus.pend_mask, pendVector());
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rf_we"}, {31'd0, bus.rf_we}, 32'd0);
    checkOutput({tag, "_rf_waddr"}, {27'd0, bus.rf_waddr}, 32'd0);
    checkOutput({tag, "_rf_wdata"}, bus.rf_wdata, 32'd0);
    checkOutput({tag, "_pend_mask"}, bus.pend_mask, 32'd0);
    checkOutput({tag, "_req_ready"}, {29'd0, bus.req_ready}, 32'd0);
  endtask

  initial begin
    logic [3*AW-1:0] ra;
    logic [3*DW-1:0] rd3;

    modelReset();
    bus.req_valid = 3'b111;
    bus.req_waddr = {5'd3, 5'd2, 5'd1};
    bus.req_wdata = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    #1;
    checkReset("por");
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] contention from reset");
    for (int c = 0; c < 4; c++)
      applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b0, 5'd0);
    applyStimulus(3'b000, '0, '0, 1'b0, 5'd0);

    $display("[TB] single MEM transfer");
    applyStimulus(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0}, 1'b0, 5'd0);
    checkOutput("single_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    applyStimulus(3'b000, '0, '0, 1'b0, 5'd0);

    $display("[TB] x0 write");
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd0}, {64'd0, 32'h0000_1234}, 1'b0, 5'd0);
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd3}, {64'd0, 32'h0000_5678}, 1'b0, 5'd0);

    $display("[TB] scoreboard");
    applyStimulus(3'b000, '0, '0, 1'b1, 5'd5);
    checkOutput("pend_rd5", bus.pend_mask, 32'h0000_0020);
    applyStimulus(3'b100, {5'd5, 5'd0, 5'd0}, {32'h0505_0505, 64'd0}, 1'b0, 5'd0);
    applyStimulus(3'b000, '0, '0, 1'b1, 5'd0);
    checkOutput("pend_cleared", bus.pend_mask, 32'h0000_0000);

    $display("[TB] set/clear collision");
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'h0909_0909}, 1'b1, 5'd9);
    applyStimulus(3'b000, '0, '0, 1'b1, 5'd9);
    checkOutput("collision_pend9", {31'd0, bus.pend_mask[9]}, 32'd1);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      ra  = (3*AW)'($urandom);
      if ($urandom_range(0, 7) == 0) ra[AW-1:0] = '0;
      rd3 = {$urandom, $urandom, $urandom};
      applyStimulus(3'($urandom_range(0, 7)), ra, rd3, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    $display("[TB] async reset mid-operation");
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    modelReset();
    @(negedge clk);
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd3}, {64'd0, 32'h0303_0303}, 1'b1, 5'd7);
    checkOutput("pre_reset_pend", bus.pend_mask, 32'h0000_0080);
    bus.req_valid = 3'b111;
    #2;
    rstn = 1'b0;
    #1;
    checkReset("async");
    modelReset();
    @(negedge clk);
    checkReset("held");
    rstn = 1'b1;
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0);
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
